seg_argmax: RTL and testbench

//  Consumes the 12-unit fixed-point feature stream of the reduction CNN and makes the
//  per-pixel segmentation decision. Pipelined signed argmax gives the class index;
//  the winning score is converted to uint confidence. Coordinates are carried alongside.
//  Per-class pixel counts are accumulated per frame and snapshotted at frame end.

---
 rtl/rdc_pkg.sv | 44 ++++
 rtl/argmax_stage.sv | 50 +++++
 rtl/rdc_delay.sv | 29 ++
 rtl/seg_argmax.sv | 209 ++++++++++++++++++++
 tb/tb_seg_argmax.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rdc_pkg.sv
// Shared constants and helpers for the reduction-CNN output blocks:
// fixed-point defaults, a ceil-log2 for port widths, the argmax tree
// level sizing and the signed-score to unsigned-confidence conversion.
package rdc_pkg;

  localparam int RDC_INT_BITW  = 5;   // integer bits incl. sign
  localparam int RDC_FRAC_BITW = 8;   // fractional bits
  localparam int RDC_UNITS     = 12;  // classes / input units

  // Ceil log2, never below 1 so it can always size a port.
  function automatic int log2_ceil(input int value);
    int result;
    result = 1;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Number of surviving candidates after `level` pairwise tree levels.
  function automatic int level_count(input int units, input int level);
    int n;
    n = units;
    for (int l = 0; l < level; l++) n = (n + 1) / 2;
    return n;
  endfunction

  // Signed fixed-point score to saturated unsigned confidence.
  // Negative scores clamp to 0; otherwise the fraction is rounded
  // (half up) down to uint_bitw bits and saturated at all ones.
  function automatic logic [31:0] score_to_uint(input int s,
                                                input int frac_bitw,
                                                input int uint_bitw);
    int r;
    if (s < 0) begin
      r = 0;
    end else if (frac_bitw == uint_bitw) begin
      r = s;
    end else begin
      r = ((s >>> (frac_bitw - uint_bitw - 1)) + 1) >>> 1;
    end
    if (r >= (1 << uint_bitw)) r = (1 << uint_bitw) - 1;
    return r;
  endfunction

endpackage

// File: rtl/argmax_stage.sv
// One level of the argmax reduction tree: N {index,score} candidates in,
// ceil(N/2) registered winners out. Scores compare signed; on a tie the
// left (lower-index) candidate wins. An unpaired last candidate passes
// through unchanged, still registered so every path has equal latency.
module argmax_stage #(
  parameter  int N  = 12,
  parameter  int CW = 4,
  parameter  int SW = 13,
  localparam int M  = (N + 1) / 2
) (
  input  logic                 clock,
  input  logic                 n_rst,
  input  logic [N-1:0][CW-1:0] idx_i,
  input  logic [N-1:0][SW-1:0] score_i,
  output logic [M-1:0][CW-1:0] idx_o,
  output logic [M-1:0][SW-1:0] score_o
);

  logic [M-1:0][CW-1:0] idx_d, idx_q;
  logic [M-1:0][SW-1:0] score_d, score_q;

  for (genvar m = 0; m < M; m++) begin : g_out
    if (2 * m + 1 < N) begin : g_pair
      logic b_wins;
      // Strictly greater, so equal scores keep the lower index.
      assign b_wins     = $signed(score_i[2*m+1]) > $signed(score_i[2*m]);
      assign idx_d[m]   = b_wins ? idx_i[2*m+1]   : idx_i[2*m];
      assign score_d[m] = b_wins ? score_i[2*m+1] : score_i[2*m];
    end else begin : g_single
      assign idx_d[m]   = idx_i[2*m];
      assign score_d[m] = score_i[2*m];
    end
  end

  // Register this level's winners.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      idx_q   <= '0;
      score_q <= '0;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      idx_q   <= idx_d;
      score_q <= score_d;
    end
  end

  assign idx_o   = idx_q;
  assign score_o = score_q;

endmodule

// File: rtl/rdc_delay.sv
// Fixed-depth, resettable delay line used to carry side-band fields
// (valid, coordinates) alongside a pipeline of matching latency.
module rdc_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clock,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [DEPTH-1:0][WIDTH-1:0] shift_d, shift_q;

  // Shift one position per clock, new sample enters at slot 0.
  always_comb begin
    shift_d[0] = d_i;
    for (int i = 1; i < DEPTH; i++) shift_d[i] = shift_q[i-1];
  end

  // Delay-line registers; cleared so no stale valid escapes after reset.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) shift_q <= '0;
    else        shift_q <= shift_d;
  end

  assign q_o = shift_q[DEPTH-1];

endmodule

// File: rtl/seg_argmax.sv
// Per-pixel segmentation decision for the reduction CNN output stream:
// pipelined signed argmax over UNITS scores, winning score converted to a
// saturated unsigned confidence, coordinates carried alongside, and a
// per-class pixel histogram snapshotted at every frame end.
module seg_argmax
  import rdc_pkg::*;
#(
  parameter  int W_HEIGHT  = -1,
  parameter  int W_WIDTH   = -1,
  parameter  int UINT_BITW = 8,
  parameter  int UNITS     = RDC_UNITS,
  parameter  int INT_BITW  = RDC_INT_BITW,
  parameter  int FRAC_BITW = RDC_FRAC_BITW,
  // Frame dims must be overridden; clamp the defaults so widths stay legal.
  localparam int H_EFF     = (W_HEIGHT > 1) ? W_HEIGHT : 2,
  localparam int W_EFF     = (W_WIDTH > 1) ? W_WIDTH : 2,
  localparam int VW        = log2_ceil(H_EFF),
  localparam int HW        = log2_ceil(W_EFF),
  localparam int CW        = log2_ceil(UNITS),
  localparam int SW        = INT_BITW + FRAC_BITW,
  localparam int HCW       = log2_ceil(H_EFF * W_EFF + 1)
) (
  input  logic                  clock,
  input  logic                  n_rst,
  input  logic                  in_enable,
  input  logic [0:SW*UNITS-1]   in_y,
  input  logic [VW-1:0]         in_vcnt,
  input  logic [HW-1:0]         in_hcnt,
  output logic                  out_enable,
  output logic [CW-1:0]         out_class,
  output logic [UINT_BITW-1:0]  out_conf,
  output logic [VW-1:0]         out_vcnt,
  output logic [HW-1:0]         out_hcnt,
  output logic                  hist_done,
  input  logic [CW-1:0]         hist_sel,
  output logic [HCW-1:0]        hist_count
);

  localparam int LV      = log2_ceil(UNITS);
  localparam int LATENCY = LV + 2;

  // ---------------------------------------------------------------------
  // Stage 0: register the raw scores. Unit k sits at slice k, MSB first.
  // ---------------------------------------------------------------------
  logic [UNITS-1:0][SW-1:0] score0_d, score0_q;
  logic [UNITS-1:0][CW-1:0] idx0;

  // Unpack the flat input vector and tag each unit with its index.
  always_comb begin
    for (int k = 0; k < UNITS; k++) begin
      score0_d[k] = in_y[k*SW +: SW];
      idx0[k]     = CW'(k);
    end
  end

  // Input score register.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) score0_q <= '0;
    else        score0_q <= score0_d;
  end

  // ---------------------------------------------------------------------
  // Reduction tree: LV registered levels down to a single winner.
  // ---------------------------------------------------------------------
  for (genvar l = 0; l < LV; l++) begin : g_lvl
    localparam int NI = level_count(UNITS, l);
    localparam int NO = level_count(UNITS, l + 1);

    logic [NI-1:0][CW-1:0] idx_in;
    logic [NI-1:0][SW-1:0] score_in;
    logic [NO-1:0][CW-1:0] idx_out;
    logic [NO-1:0][SW-1:0] score_out;

    if (l == 0) begin : g_src_in
      assign idx_in   = idx0;
      assign score_in = score0_q;
    end else begin : g_src_prev
      assign idx_in   = g_lvl[l-1].idx_out;
      assign score_in = g_lvl[l-1].score_out;
    end

    argmax_stage #(
      .N  (NI),
      .CW (CW),
      .SW (SW)
    ) u_stage (
      .clock   (clock),
      .n_rst   (n_rst),
      .idx_i   (idx_in),
      .score_i (score_in),
      .idx_o   (idx_out),
      .score_o (score_out)
    );
  end

  // ---------------------------------------------------------------------
  // Final stage: register class and converted confidence.
  // ---------------------------------------------------------------------
  logic [CW-1:0]        win_idx;
  logic signed [SW-1:0] win_score;
  logic [CW-1:0]        class_d, class_q;
  logic [UINT_BITW-1:0] conf_d, conf_q;

  assign win_idx   = g_lvl[LV-1].idx_out[0];
  assign win_score = g_lvl[LV-1].score_out[0];

  // Convert the winning score to unsigned confidence.
  always_comb begin
    class_d = win_idx;
    conf_d  = UINT_BITW'(score_to_uint(int'(win_score), FRAC_BITW, UINT_BITW));
  end

  // Output class/confidence register.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      class_q <= '0;
      conf_q  <= '0;
    end else begin
      class_q <= class_d;
      conf_q  <= conf_d;
    end
  end

  assign out_class = class_q;
  assign out_conf  = conf_q;

  // Valid and coordinates ride a delay line matched to the datapath.
  logic [VW+HW:0] side_in, side_out;

  assign side_in = {in_enable, in_vcnt, in_hcnt};

  rdc_delay #(
    .WIDTH (VW + HW + 1),
    .DEPTH (LATENCY)
  ) u_side_dly (
    .clock (clock),
    .n_rst (n_rst),
    .d_i   (side_in),
    .q_o   (side_out)
  );

  assign out_enable = side_out[VW+HW];
  assign out_vcnt   = side_out[HW +: VW];
  assign out_hcnt   = side_out[HW-1:0];

  // ---------------------------------------------------------------------
  // Histogram: running per-class counts, snapshot at frame end.
  // ---------------------------------------------------------------------
  logic                      frame_end;
  logic [UNITS-1:0]          hit;
  logic [UNITS-1:0][HCW-1:0] running_d, running_q;
  logic [UNITS-1:0][HCW-1:0] snapshot_d, snapshot_q;
  logic                      hist_done_d, hist_done_q;
  logic [HCW-1:0]            hist_count_d, hist_count_q;

  assign frame_end = out_enable
                   && (out_vcnt == VW'(H_EFF - 1))
                   && (out_hcnt == HW'(W_EFF - 1));

  // One-hot of the class receiving the current output pixel.
  always_comb begin
    for (int u = 0; u < UNITS; u++) hit[u] = out_enable && (out_class == CW'(u));
  end

  // Count pixels; at frame end fold the last pixel into the snapshot and
  // restart the running counts from zero.
  always_comb begin
    // NOTE: every output gets a default first, so no path infers a latch.
    running_d   = running_q;
    snapshot_d  = snapshot_q;
    hist_done_d = 1'b0;
    for (int u = 0; u < UNITS; u++) begin
      if (frame_end) begin
        snapshot_d[u] = running_q[u] + HCW'(hit[u]);
        running_d[u]  = '0;
      end else begin
        running_d[u]  = running_q[u] + HCW'(hit[u]);
      end
    end
    if (frame_end) hist_done_d = 1'b1;
  end

  // Snapshot read mux; out-of-range selects read zero.
  always_comb begin
    hist_count_d = '0;
    if (int'(hist_sel) < UNITS) hist_count_d = snapshot_q[hist_sel];
  end

  // Histogram state registers.
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      // NOTE: these counter banks are flops, not RAM, and must read zero
      // after reset, so they are cleared here like any other state.
      running_q    <= '0;
      snapshot_q   <= '0;
      hist_done_q  <= 1'b0;
      hist_count_q <= '0;
    end else begin
      running_q    <= running_d;
      snapshot_q   <= snapshot_d;
      hist_done_q  <= hist_done_d;
      hist_count_q <= hist_count_d;
    end
  end

  assign hist_done  = hist_done_q;
  assign hist_count = hist_count_q;

endmodule

// File: tb/tb_seg_argmax.sv
// Directed bench for seg_argmax: 12 units, 4 rows x 8 columns incl. blanking.
module tb_seg_argmax;

  localparam int H     = 4;
  localparam int W     = 8;
  localparam int UNITS = 12;
  localparam int SW    = 13;
  localparam int CW    = 4;
  localparam int VW    = 2;
  localparam int HW    = 3;
  localparam int HCW   = 6;
  localparam int UB    = 8;

  logic                clock = 1'b0;
  logic                n_rst;
  logic                in_enable;
  logic [0:SW*UNITS-1] in_y;
  logic [VW-1:0]       in_vcnt;
  logic [HW-1:0]       in_hcnt;
  logic                out_enable;
  logic [CW-1:0]       out_class;
  logic [UB-1:0]       out_conf;
  logic [VW-1:0]       out_vcnt;
  logic [HW-1:0]       out_hcnt;
  logic                hist_done;
  logic [CW-1:0]       hist_sel;
  logic [HCW-1:0]      hist_count;

  int n_vec  = 0;
  int n_miss = 0;

  seg_argmax #(
    .W_HEIGHT  (H),
    .W_WIDTH   (W),
    .UINT_BITW (UB),
    .UNITS     (UNITS),
    .INT_BITW  (5),
    .FRAC_BITW (8)
  ) dut (
    .clock      (clock),
    .n_rst      (n_rst),
    .in_enable  (in_enable),
    .in_y       (in_y),
    .in_vcnt    (in_vcnt),
    .in_hcnt    (in_hcnt),
    .out_enable (out_enable),
    .out_class  (out_class),
    .out_conf   (out_conf),
    .out_vcnt   (out_vcnt),
    .out_hcnt   (out_hcnt),
    .hist_done  (hist_done),
    .hist_sel   (hist_sel),
    .hist_count (hist_count)
  );

  always #5 clock = ~clock;

  // Event monitor sampled on the falling edge.
  int cyc      = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int last_cyc = -1;
  int en_cnt   = 0;

  always @(negedge clock) begin
    cyc++;
    if (hist_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (out_enable === 1'b1) begin
      en_cnt++;
      if (out_vcnt == VW'(H - 1) && out_hcnt == HW'(W - 1)) last_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_all(input logic [SW-1:0] v);
    for (int k = 0; k < UNITS; k++) in_y[k*SW +: SW] = v;
  endtask

  task automatic set_unit(input int k, input logic [SW-1:0] v);
    in_y[k*SW +: SW] = v;
  endtask

  // One pixel whose winning class is cls (+1.0 on that unit, 0 elsewhere).
  task automatic drive_px(input logic en, input int cls, input int v, input int h);
    set_all('0);
    set_unit(cls, 13'h0100);
    in_enable = en;
    in_vcnt   = VW'(v);
    in_hcnt   = HW'(h);
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      step();
      seen = hist_done;
    end
    check(tag, seen, 1);
  endtask

  // Frames 1 and 2: 16 pixels each in the 4x4 active area (cols 4..7).
  function automatic int frame_class(input int i);
    if (i < 10)  return 0;
    if (i < 16)  return 3;
    if (i == 16) return 5;
    return 1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst     = 1'b0;
    in_enable = 1'b0;
    in_y      = '0;
    in_vcnt   = '0;
    in_hcnt   = '0;
    hist_sel  = '0;
    repeat (2) step();

    check("rst out_enable", out_enable, 0);
    check("rst out_class",  out_class,  0);
    check("rst out_conf",   out_conf,   0);
    check("rst out_vcnt",   out_vcnt,   0);
    check("rst hist_count", hist_count, 0);
    check("rst hist_done",  hist_done,  0);
    n_rst = 1'b1;
    step();

    // Unit 7 = +1.0, others -1.0, pixel at (3,5).
    set_all(13'h1F00);
    set_unit(7, 13'h0100);
    in_enable = 1'b1;
    in_vcnt   = 2'd3;
    in_hcnt   = 3'd5;
    step();
    in_enable = 1'b0;
    set_all('0);
    repeat (4) step();
    check("t1 early enable", out_enable, 0);
    step();
    check("t1 enable", out_enable, 1);
    check("t1 class",  out_class,  7);
    check("t1 conf",   out_conf,   255);
    check("t1 vcnt",   out_vcnt,   3);
    check("t1 hcnt",   out_hcnt,   5);
    step();
    check("t1 late enable", out_enable, 0);

    // Tie between units 2 and 9 -> lower index.
    set_all('0);
    set_unit(2, 13'h0040);
    set_unit(9, 13'h0040);
    in_enable = 1'b1;
    in_vcnt   = 2'd1;
    in_hcnt   = 3'd2;
    step();
    in_enable = 1'b0;
    repeat (5) step();
    check("t2 enable", out_enable, 1);
    check("t2 class",  out_class,  2);
    check("t2 conf",   out_conf,   64);
    check("t2 hcnt",   out_hcnt,   2);

    // All negative, max at unit 11 = 0x1F00 (-1.0).
    for (int k = 0; k < 11; k++) set_unit(k, 13'(13'h1E00 + 8 * k));
    set_unit(11, 13'h1F00);
    in_enable = 1'b1;
    in_vcnt   = 2'd2;
    in_hcnt   = 3'd0;
    step();
    in_enable = 1'b0;
    repeat (5) step();
    check("t3 enable", out_enable, 1);
    check("t3 class",  out_class,  11);
    check("t3 conf",   out_conf,   0);

    // No frame end yet: snapshot still reads zero.
    hist_sel = 4'd7;
    step();
    check("pre-frame hist_count", hist_count, 0);
    check("pre-frame no done",    done_cnt,   0);

    // Clear running counts left by the single-pixel tests.
    n_rst = 1'b0;
    step();
    n_rst = 1'b1;
    step();

    fork
      begin
        for (int i = 0; i < 32; i++) begin
          drive_px(1'b1, frame_class(i), (i % 16) / 4, 4 + (i % 16) % 4);
          step();
        end
        in_enable = 1'b0;
      end
      begin
        wait_done("f1 hist_done seen");
        hist_sel = 4'd0;
        step();
        check("f1 hist_done one cycle", hist_done, 0);
        check("f1 done after last px", done_cyc - last_cyc, 1);
        check("f1 class0 count", hist_count, 10);
        hist_sel = 4'd3;
        step();
        check("f1 class3 count", hist_count, 6);
        hist_sel = 4'd12;
        step();
        check("f1 sel12 count", hist_count, 0);
        hist_sel = 4'd5;
        step();
        check("f1 class5 count", hist_count, 0);
        check("f1 done pulses", done_cnt, 1);

        wait_done("f2 hist_done seen");
        hist_sel = 4'd5;
        step();
        check("f2 class5 count", hist_count, 1);
        hist_sel = 4'd1;
        step();
        check("f2 class1 count", hist_count, 15);
        hist_sel = 4'd0;
        step();
        check("f2 class0 count", hist_count, 0);
        check("f2 done pulses", done_cnt, 2);
      end
    join

    // Reset with a frame's last pixel still in flight.
    hist_sel = 4'd1;
    step();
    check("pre-rst hist_count", hist_count, 15);
    for (int k = 0; k < 8; k++) begin
      drive_px(1'b1, 2, k / 2, 6 + k % 2);
      step();
    end
    check("pre-rst out_enable", out_enable, 1);
    en_cnt    = 0;
    in_enable = 1'b0;
    n_rst     = 1'b0;
    #1;
    check("rst-mid out_enable", out_enable, 0);
    check("rst-mid hist_count", hist_count, 0);
    check("rst-mid out_class",  out_class,  0);
    step();
    step();
    n_rst = 1'b1;
    repeat (20) step();
    check("post-rst no done",      done_cnt,   2);
    check("post-rst no pixels",    en_cnt,     0);
    check("post-rst snapshot",     hist_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
